// File: rtl/pro_defs.sv
// Shared definitions for the processor run controller.
//   state_t : FSM state encodings (3-bit)
//   IMEM_W  : instruction memory word width
package pro_defs;

  localparam int IMEM_W = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ARM  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/pro_run_ctrl.sv
// Host-side sequencer for the processor.
// Streams a program into instruction memory (addr 0,1,2,...), parks the bus at
// addr 0, then runs the processor until halt, abort or the cycle budget ends.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   load_valid/ready/data/last   program word stream from the host
//   start, halt, abort           run control
//   addr, wr, wdata, working     processor-side bus (all registered)
//   busy, done, err              status; done is a 1-cycle pulse, err is sticky
//   load_count, run_cycles       words in the current program, cycles of last run
module pro_run_ctrl
  import pro_defs::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int MAX_RUN    = 25,
  localparam int CW        = $clog2(IMEM_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [IMEM_W-1:0] load_data,
  input  logic              load_last,
  input  logic              start,
  input  logic              halt,
  input  logic              abort,
  output logic [31:0]       addr,
  output logic              wr,
  output logic [IMEM_W-1:0] wdata,
  output logic              working,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CW-1:0]     load_count,
  output logic [31:0]       run_cycles
);

  localparam logic [CW-1:0] DEPTH_C   = CW'(IMEM_DEPTH);
  localparam logic [31:0]   RUN_LAST  = 32'(MAX_RUN - 1);
  localparam bit            BUDGET_ON = (MAX_RUN != 0);

  state_t        state;
  logic [CW-1:0] ptr;
  logic [CW-1:0] ptr_inc;
  logic          accept;
  logic          run_end;

  assign accept  = load_valid && load_ready;
  assign ptr_inc = ptr + CW'(1);
  // halt and budget expiry together still make a single end
  assign run_end = halt || (BUDGET_ON && (run_cycles == RUN_LAST));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      load_ready <= 1'b1;
      addr       <= '0;
      wr         <= 1'b0;
      wdata      <= '0;
      working    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      load_count <= '0;
      run_cycles <= '0;
    end else if (abort) begin
      // abort wins over everything else; err and counters are left alone
      state      <= S_IDLE;
      ptr        <= '0;
      load_ready <= 1'b1;
      addr       <= '0;
      wr         <= 1'b0;
      wdata      <= '0;
      working    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wr   <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          ptr        <= '0;
          load_ready <= 1'b1;
          if (accept) begin
            // first word of a new program: restart counters and clear err
            addr       <= '0;
            wr         <= 1'b1;
            wdata      <= load_data;
            ptr        <= CW'(1);
            load_count <= CW'(1);
            run_cycles <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
            if (load_last) begin
              state      <= S_ARM;
              load_ready <= 1'b0;
            end else begin
              state      <= S_LOAD;
              load_ready <= (CW'(1) < DEPTH_C);
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            addr       <= 32'(ptr);
            wr         <= 1'b1;
            wdata      <= load_data;
            ptr        <= ptr_inc;
            load_count <= load_count + CW'(1);
            if (load_last) begin
              state      <= S_ARM;
              load_ready <= 1'b0;
            end else begin
              load_ready <= (ptr_inc < DEPTH_C);
            end
          end else if (ptr == DEPTH_C) begin
            // memory full and no last word seen: flag overflow, drop the rest
            err        <= 1'b1;
            state      <= S_ARM;
            load_ready <= 1'b0;
          end
        end
        S_ARM: begin
          // park the bus one cycle after the final write
          load_ready <= 1'b0;
          addr       <= '0;
          wdata      <= '0;
          if (start) begin
            working    <= 1'b1;
            run_cycles <= '0;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          run_cycles <= run_cycles + 32'd1;
          if (run_end) begin
            working <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          load_ready <= 1'b1;
          ptr        <= '0;
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          working    <= 1'b0;
          load_ready <= 1'b1;
          ptr        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pro_run_ctrl.sv
module tb_pro_run_ctrl;
  import pro_defs::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid, load_last, start, halt, abort;
  logic [31:0] load_data;

  // main instance: IMEM_DEPTH=256, MAX_RUN=25
  logic        load_ready, wr, working, busy, done, err;
  logic [31:0] addr, wdata, run_cycles;
  logic [8:0]  load_count;

  // small instance: IMEM_DEPTH=4 for overflow
  logic        s_load_ready, s_wr, s_working, s_busy, s_done, s_err;
  logic [31:0] s_addr, s_wdata, s_run_cycles;
  logic [2:0]  s_load_count;

  always #5 clock = ~clock;

  pro_run_ctrl #(.IMEM_DEPTH(256), .MAX_RUN(25)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .start(start), .halt(halt),
    .abort(abort), .addr(addr), .wr(wr), .wdata(wdata), .working(working),
    .busy(busy), .done(done), .err(err), .load_count(load_count),
    .run_cycles(run_cycles)
  );

  pro_run_ctrl #(.IMEM_DEPTH(4), .MAX_RUN(25)) u_small (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(s_load_ready),
    .load_data(load_data), .load_last(load_last), .start(start), .halt(halt),
    .abort(abort), .addr(s_addr), .wr(s_wr), .wdata(s_wdata), .working(s_working),
    .busy(s_busy), .done(s_done), .err(s_err), .load_count(s_load_count),
    .run_cycles(s_run_cycles)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    start = 1'b0; halt = 1'b0; abort = 1'b0;
  endtask

  task automatic load1(input logic [31:0] d);
    load_valid = 1'b1; load_data = d; load_last = 1'b1;
    tick;
    idle_in;
  endtask

  // wr and working must never overlap
  always @(negedge clock) begin
    if (!reset) begin
      total++;
      if ((wr && working) || (s_wr && s_working)) begin
        bad++;
        $display("FAIL invariant: wr=%0b working=%0b s_wr=%0b s_working=%0b, want no overlap",
                 wr, working, s_wr, s_working);
      end
    end
  end

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        last;
    logic        st;
    logic        rdy;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic        work;
    logic        bsy;
    logic [8:0]  lc;
  } vec_t;

  function automatic vec_t mkv(logic lv, logic [31:0] ld, logic last, logic st,
                               logic rdy, logic w, logic [31:0] a, logic [31:0] wd,
                               logic work, logic bsy, logic [8:0] lc);
    vec_t v;
    v.lv = lv; v.ld = ld; v.last = last; v.st = st;
    v.rdy = rdy; v.w = w; v.a = a; v.wd = wd; v.work = work; v.bsy = bsy; v.lc = lc;
    return v;
  endfunction

  vec_t        tbl[11];
  logic        v;
  logic [31:0] word;
  int          n;

  initial begin
    // T1 table: 8 back-to-back words, two parked ARM cycles, then start
    for (int i = 0; i < 8; i++) begin
      word   = 32'h10F00080 + 32'(i) * 32'h00010001;
      tbl[i] = mkv(1'b1, word, (i == 7), 1'b0, (i != 7), 1'b1, 32'(i), word,
                   1'b0, 1'b1, 9'(i + 1));
    end
    tbl[8]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 9'd8);
    tbl[9]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 9'd8);
    tbl[10] = mkv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 9'd8);

    // reset values
    idle_in;
    reset = 1'b1;
    tick; tick;
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_working", 32'(working), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_lc", 32'(load_count), 32'd0);
    chk("rst_rc", run_cycles, 32'd0);
    reset = 1'b0;

    // T1 + start of T2
    for (int i = 0; i < 11; i++) begin
      load_valid = tbl[i].lv; load_data = tbl[i].ld;
      load_last  = tbl[i].last; start = tbl[i].st;
      tick;
      chk($sformatf("t1_ready[%0d]", i), 32'(load_ready), 32'(tbl[i].rdy));
      chk($sformatf("t1_wr[%0d]", i), 32'(wr), 32'(tbl[i].w));
      chk($sformatf("t1_addr[%0d]", i), addr, tbl[i].a);
      chk($sformatf("t1_wdata[%0d]", i), wdata, tbl[i].wd);
      chk($sformatf("t1_working[%0d]", i), 32'(working), 32'(tbl[i].work));
      chk($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("t1_done[%0d]", i), 32'(done), 32'd0);
      chk($sformatf("t1_lc[%0d]", i), 32'(load_count), 32'(tbl[i].lc));
      if (i == 9) chk("t1_state_arm", 32'(dut.state), 32'(S_ARM));
    end
    idle_in;

    // T2: 25 working cycles then one done pulse
    chk("t2_rc0", run_cycles, 32'd0);
    for (int k = 1; k <= 24; k++) begin
      tick;
      chk($sformatf("t2_working[%0d]", k), 32'(working), 32'd1);
      chk($sformatf("t2_rc[%0d]", k), run_cycles, 32'(k));
      chk($sformatf("t2_done[%0d]", k), 32'(done), 32'd0);
    end
    tick;
    chk("t2_end_working", 32'(working), 32'd0);
    chk("t2_end_done", 32'(done), 32'd1);
    chk("t2_end_rc", run_cycles, 32'd25);
    chk("t2_end_busy", 32'(busy), 32'd1);
    tick;
    chk("t2_after_done", 32'(done), 32'd0);
    chk("t2_after_busy", 32'(busy), 32'd0);
    chk("t2_after_ready", 32'(load_ready), 32'd1);
    chk("t2_hold_rc", run_cycles, 32'd25);
    chk("t2_hold_lc", 32'(load_count), 32'd8);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t2_idle_start_working", 32'(working), 32'd0);
    chk("t2_idle_start_busy", 32'(busy), 32'd0);

    // T3: valid pattern 1,0,0,1 repeated, 4 words
    n = 0;
    for (int c = 0; c < 8; c++) begin
      v = ((c % 4) == 0) || ((c % 4) == 3);
      load_valid = v;
      load_data  = 32'hA0000000 + 32'(n);
      load_last  = v && (n == 3);
      tick;
      chk($sformatf("t3_wr[%0d]", c), 32'(wr), 32'(v));
      if (v) begin
        chk($sformatf("t3_addr[%0d]", c), addr, 32'(n));
        chk($sformatf("t3_wdata[%0d]", c), wdata, 32'hA0000000 + 32'(n));
        n++;
      end
    end
    idle_in;
    tick;
    chk("t3_state_arm", 32'(dut.state), 32'(S_ARM));
    chk("t3_lc", 32'(load_count), 32'd4);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t3_abort_busy", 32'(busy), 32'd0);

    // T4: overflow on the depth-4 instance
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hB0000000 + 32'(i);
      load_last  = (i == 5);
      tick;
      chk($sformatf("t4_wr[%0d]", i), 32'(s_wr), 32'(i < 4));
      if (i < 4) chk($sformatf("t4_addr[%0d]", i), s_addr, 32'(i));
      chk($sformatf("t4_ready[%0d]", i), 32'(s_load_ready), 32'(i < 3));
    end
    idle_in;
    chk("t4_err", 32'(s_err), 32'd1);
    chk("t4_lc", 32'(s_load_count), 32'd4);
    chk("t4_state_arm", 32'(u_small.state), 32'(S_ARM));
    chk("t4_big_lc", 32'(load_count), 32'd6);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t4_abort_keeps_err", 32'(s_err), 32'd1);
    chk("t4_abort_busy", 32'(s_busy), 32'd0);

    // T5: halt on the 10th working cycle
    load1(32'hC0000000);
    chk("t5_err_cleared", 32'(s_err), 32'd0);
    chk("t5_rc_cleared", run_cycles, 32'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) tick;
    chk("t5_pre_halt_working", 32'(working), 32'd1);
    halt = 1'b1;
    tick;
    halt = 1'b0;
    chk("t5_halt_working", 32'(working), 32'd0);
    chk("t5_halt_done", 32'(done), 32'd1);
    chk("t5_halt_rc", run_cycles, 32'd10);
    tick;
    chk("t5_done_once", 32'(done), 32'd0);
    chk("t5_busy_low", 32'(busy), 32'd0);
    tick;
    chk("t5_no_second_done", 32'(done), 32'd0);

    // halt coinciding with budget expiry: one done
    load1(32'hC0000001);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 24; k++) tick;
    halt = 1'b1;
    tick;
    halt = 1'b0;
    chk("t5_both_done", 32'(done), 32'd1);
    chk("t5_both_rc", run_cycles, 32'd25);
    tick;
    chk("t5_both_single", 32'(done), 32'd0);

    // halt and abort together: abort wins
    load1(32'hC0000002);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    halt = 1'b1; abort = 1'b1;
    tick;
    idle_in;
    chk("t5_ha_working", 32'(working), 32'd0);
    chk("t5_ha_done", 32'(done), 32'd0);
    chk("t5_ha_busy", 32'(busy), 32'd0);
    chk("t5_ha_ready", 32'(load_ready), 32'd1);
    tick;
    chk("t5_ha_no_done", 32'(done), 32'd0);

    // abort beats start in ARM
    load1(32'hC0000003);
    start = 1'b1; abort = 1'b1;
    tick;
    idle_in;
    chk("t5_as_working", 32'(working), 32'd0);
    chk("t5_as_busy", 32'(busy), 32'd0);

    // T6: abort on 3rd load word, then reload from addr 0
    load_valid = 1'b1; load_last = 1'b0;
    load_data = 32'hD0000000; tick;
    load_data = 32'hD0000001; tick;
    load_data = 32'hD0000002; abort = 1'b1; tick;
    idle_in;
    chk("t6_abort_wr", 32'(wr), 32'd0);
    chk("t6_abort_busy", 32'(busy), 32'd0);
    chk("t6_abort_ready", 32'(load_ready), 32'd1);
    load_valid = 1'b1; load_data = 32'hD0000009; tick;
    chk("t6_reload_addr", addr, 32'd0);
    chk("t6_reload_wr", 32'(wr), 32'd1);
    chk("t6_reload_wdata", wdata, 32'hD0000009);
    chk("t6_reload_lc", 32'(load_count), 32'd1);
    load_data = 32'hD000000A; load_last = 1'b1; tick;
    chk("t6_reload_addr1", addr, 32'd1);
    idle_in;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    chk("t6_running", 32'(working), 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t6_rst_working", 32'(working), 32'd0);
    chk("t6_rst_rc", run_cycles, 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ready", 32'(load_ready), 32'd1);
    chk("t6_rst_lc", 32'(load_count), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
